// File: rtl/sparce_sasa_cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sparce_sasa_cam_pkg
// Brief    : Shared types, register offsets and field positions for the SASA CAM.
// Revision : 1.0 - initial fully associative release
// ============================================================================
package sparce_sasa_cam_pkg;

    typedef enum logic {
        SASA_COND_OR  = 1'b0,
        SASA_COND_AND = 1'b1
    } sasa_cond_t;

    // The entry struct carries the widest legal skip; instances truncate.
    localparam int SASA_SKIP_MAX_W = 16;

    typedef struct packed {
        logic [31:0]                preceding_pc;
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic [SASA_SKIP_MAX_W-1:0] skip;
        sasa_cond_t                 condition;
    } sasa_entry_t;

    localparam logic [31:0] SASA_OFF_PC   = 32'd0;
    localparam logic [31:0] SASA_OFF_CFG  = 32'd4;
    localparam logic [31:0] SASA_OFF_CTRL = 32'd8;

    localparam int SASA_RS1_LSB  = 0;
    localparam int SASA_RS2_LSB  = 5;
    localparam int SASA_SKIP_LSB = 10;
    localparam int SASA_COND_BIT = 31;

    localparam int SASA_CTRL_FLUSH_BIT = 0;
    localparam int SASA_CTRL_CLR_BIT   = 1;

    typedef enum logic [0:0] {
        WR_IDLE    = 1'b0,
        WR_PC_HELD = 1'b1
    } sasa_wr_state_t;

endpackage
`default_nettype wire

// File: rtl/sparce_sasa_entry.sv
`default_nettype none
// ============================================================================
// Module   : sparce_sasa_entry
// Brief    : One CAM entry: stored fields, valid bit, lookup and dedup compare.
// Revision : 1.0 - initial fully associative release
// ============================================================================
module sparce_sasa_entry
    import sparce_sasa_cam_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_wr_en,
    input  logic        i_flush,
    input  sasa_entry_t i_entry,
    input  logic [31:0] i_lookup_pc,
    input  logic [31:0] i_commit_pc,
    output logic        o_valid,
    output sasa_entry_t o_entry,
    output logic        o_hit,
    output logic        o_dup
);

    logic        r_valid;
    sasa_entry_t r_entry;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_wr_en) begin
                r_valid <= 1'b1;
            end
            if (i_wr_en) begin
                r_entry <= i_entry;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;
    assign o_hit   = r_valid && (r_entry.preceding_pc == i_lookup_pc);
    assign o_dup   = r_valid && (r_entry.preceding_pc == i_commit_pc);

endmodule
`default_nettype wire

// File: rtl/sparce_sasa_cam.sv
`default_nettype none
// ============================================================================
// Module   : sparce_sasa_cam
// Brief    : N-entry SASA CAM with FIFO replacement, in-place update and flush.
// Revision : 1.0 - initial fully associative release
// ============================================================================
module sparce_sasa_cam
    import sparce_sasa_cam_pkg::*;
#(
    parameter int          SASA_ENTRIES = 16,
    parameter logic [31:0] SASA_ADDR    = 32'h0000_3000,
    parameter int          SKIP_W       = 5
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [31:0]                     pc,
    input  logic                            sasa_enable,
    input  logic                            sasa_wen,
    input  logic [31:0]                     sasa_addr,
    input  logic [31:0]                     sasa_data,
    output logic                            valid,
    output logic [31:0]                     preceding_pc,
    output logic [4:0]                      sasa_rs1,
    output logic [4:0]                      sasa_rs2,
    output logic [SKIP_W-1:0]               insts_to_skip,
    output sasa_cond_t                      condition,
    output logic [$clog2(SASA_ENTRIES):0]   occupancy,
    output logic [31:0]                     hit_count
);

    localparam int c_IDX_W = $clog2(SASA_ENTRIES);

    sasa_wr_state_t        r_state, w_state_next;
    logic [31:0]           r_pend_pc;
    logic [c_IDX_W-1:0]    r_wr_ptr;
    logic [c_IDX_W:0]      r_occupancy;
    logic [31:0]           r_hit_count;

    logic                  w_wr_pc, w_wr_cfg, w_wr_ctrl;
    logic                  w_commit, w_flush, w_clr_hits;
    sasa_entry_t           w_new_entry;
    sasa_entry_t           w_entries [SASA_ENTRIES];
    logic [SASA_ENTRIES-1:0] w_valid_vec, w_hit_vec, w_dup_vec;
    logic                  w_any_dup;
    logic [c_IDX_W-1:0]    w_dup_idx, w_slot;
    sasa_entry_t           w_sel;
    logic                  w_unused;

    assign w_wr_pc    = sasa_wen && (sasa_addr == SASA_ADDR + SASA_OFF_PC);
    assign w_wr_cfg   = sasa_wen && (sasa_addr == SASA_ADDR + SASA_OFF_CFG);
    assign w_wr_ctrl  = sasa_wen && (sasa_addr == SASA_ADDR + SASA_OFF_CTRL);
    assign w_commit   = w_wr_cfg && (r_state == WR_PC_HELD);
    assign w_flush    = w_wr_ctrl && sasa_data[SASA_CTRL_FLUSH_BIT];
    assign w_clr_hits = w_wr_ctrl && sasa_data[SASA_CTRL_CLR_BIT];

    always_comb begin
        w_new_entry              = '0;
        w_new_entry.preceding_pc = r_pend_pc;
        w_new_entry.rs1          = sasa_data[SASA_RS1_LSB +: 5];
        w_new_entry.rs2          = sasa_data[SASA_RS2_LSB +: 5];
        w_new_entry.skip[SKIP_W-1:0] = sasa_data[SASA_SKIP_LSB +: SKIP_W];
        w_new_entry.condition    = sasa_cond_t'(sasa_data[SASA_COND_BIT]);
    end

    // Re-writing an already stored PC must land in its existing slot.
    always_comb begin
        w_any_dup = 1'b0;
        w_dup_idx = '0;
        for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
            if (w_dup_vec[i]) begin
                w_any_dup = 1'b1;
                w_dup_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_slot = w_any_dup ? w_dup_idx : r_wr_ptr;

    generate
        for (genvar gi = 0; gi < SASA_ENTRIES; gi++) begin : g_entry
            sparce_sasa_entry u_entry (
                .CLK         (CLK),
                .nRST        (nRST),
                .i_wr_en     (w_commit && (w_slot == c_IDX_W'(gi))),
                .i_flush     (w_flush),
                .i_entry     (w_new_entry),
                .i_lookup_pc (pc),
                .i_commit_pc (r_pend_pc),
                .o_valid     (w_valid_vec[gi]),
                .o_entry     (w_entries[gi]),
                .o_hit       (w_hit_vec[gi]),
                .o_dup       (w_dup_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_flush) begin
            w_state_next = WR_IDLE;
        end else if (w_wr_pc) begin
            w_state_next = WR_PC_HELD;
        end else if (w_commit) begin
            w_state_next = WR_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pend_pc   <= '0;
            r_wr_ptr    <= '0;
            r_occupancy <= '0;
        end else begin
            if (w_wr_pc) begin
                r_pend_pc <= sasa_data;
            end
            if (w_flush) begin
                r_wr_ptr    <= '0;
                r_occupancy <= '0;
            end else if (w_commit && !w_any_dup) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (!w_valid_vec[r_wr_ptr]) begin
                    r_occupancy <= r_occupancy + 1'b1;
                end
            end
        end
    end

    // Lowest matching index wins should dedup ever be bypassed.
    always_comb begin
        w_sel = '0;
        if (sasa_enable) begin
            for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
                if (w_hit_vec[i]) begin
                    w_sel = w_entries[i];
                end
            end
        end
    end

    assign valid         = sasa_enable && (|w_hit_vec);
    assign preceding_pc  = w_sel.preceding_pc;
    assign sasa_rs1      = w_sel.rs1;
    assign sasa_rs2      = w_sel.rs2;
    assign insts_to_skip = w_sel.skip[SKIP_W-1:0];
    assign condition     = w_sel.condition;
    assign occupancy     = r_occupancy;
    assign hit_count     = r_hit_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_count <= '0;
        end else if (w_clr_hits) begin
            r_hit_count <= '0;
        end else if (valid && (r_hit_count != 32'hFFFF_FFFF)) begin
            r_hit_count <= r_hit_count + 32'd1;
        end
    end

    assign w_unused = ^{sasa_data, w_sel.skip};

endmodule
`default_nettype wire

// File: tb/tb_sparce_sasa_cam.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparce_sasa_cam
// Brief    : Directed self-checking bench for the SASA CAM.
// Revision : 1.0 - initial fully associative release
// ============================================================================
module tb_sparce_sasa_cam;
    import sparce_sasa_cam_pkg::*;

    localparam logic [31:0] c_BASE = 32'h0000_3000;
    localparam logic [31:0] c_PC   = c_BASE + 32'd0;
    localparam logic [31:0] c_CFG  = c_BASE + 32'd4;
    localparam logic [31:0] c_CTRL = c_BASE + 32'd8;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] pc = '0;
    logic        sasa_enable = 1'b0;
    logic        sasa_wen = 1'b0;
    logic [31:0] sasa_addr = '0;
    logic [31:0] sasa_data = '0;
    logic        valid;
    logic [31:0] preceding_pc;
    logic [4:0]  sasa_rs1, sasa_rs2;
    logic [4:0]  insts_to_skip;
    sasa_cond_t  condition;
    logic [4:0]  occupancy;
    logic [31:0] hit_count;

    int n_checks = 0;
    int n_errors = 0;

    sparce_sasa_cam #(
        .SASA_ENTRIES (16),
        .SASA_ADDR    (c_BASE),
        .SKIP_W       (5)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pc            (pc),
        .sasa_enable   (sasa_enable),
        .sasa_wen      (sasa_wen),
        .sasa_addr     (sasa_addr),
        .sasa_data     (sasa_data),
        .valid         (valid),
        .preceding_pc  (preceding_pc),
        .sasa_rs1      (sasa_rs1),
        .sasa_rs2      (sasa_rs2),
        .insts_to_skip (insts_to_skip),
        .condition     (condition),
        .occupancy     (occupancy),
        .hit_count     (hit_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        sasa_wen  = 1'b1;
        sasa_addr = addr;
        sasa_data = data;
        tick();
        sasa_wen  = 1'b0;
        sasa_addr = '0;
        sasa_data = '0;
    endtask

    // Drive a lookup between edges so hit_count is not disturbed.
    task automatic look(input logic [31:0] p);
        pc = p;
        sasa_enable = 1'b1;
        #1;
    endtask

    task automatic unlook();
        sasa_enable = 1'b0;
        #1;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        nRST = 1'b1;
        tick();
        look(32'h100);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ppc", preceding_pc, 32'd0);
        chk("rst_skip", 32'(insts_to_skip), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        unlook();

        // First entry; lookup in the commit cycle sees old contents
        wr(c_PC, 32'h100);
        pc = 32'h100;
        sasa_enable = 1'b1;
        sasa_wen = 1'b1;
        sasa_addr = c_CFG;
        sasa_data = 32'h8000_0C41;
        #1;
        chk("commit_cycle_valid", 32'(valid), 32'd0);
        tick();
        sasa_wen = 1'b0;
        #1;
        chk("e0_valid", 32'(valid), 32'd1);
        chk("e0_ppc", preceding_pc, 32'h100);
        chk("e0_rs1", 32'(sasa_rs1), 32'd1);
        chk("e0_rs2", 32'(sasa_rs2), 32'd2);
        chk("e0_skip", 32'(insts_to_skip), 32'd3);
        chk("e0_cond", 32'(condition), 32'(SASA_COND_AND));
        chk("e0_occ", 32'(occupancy), 32'd1);
        unlook();
        chk("e0_hits", hit_count, 32'd0);

        // Word 1 in IDLE and a stray address are ignored
        wr(c_CFG, 32'h0000_0421);
        wr(c_BASE + 32'd12, 32'h3);
        chk("idle_w1_occ", 32'(occupancy), 32'd1);
        look(32'h0);
        chk("idle_w1_nohit", 32'(valid), 32'd0);
        unlook();

        // In-place update of PC 0x100
        wr(c_PC, 32'h100);
        wr(c_CFG, 32'h0000_1C41);
        look(32'h100);
        chk("upd_valid", 32'(valid), 32'd1);
        chk("upd_skip", 32'(insts_to_skip), 32'd7);
        chk("upd_cond", 32'(condition), 32'(SASA_COND_OR));
        chk("upd_occ", 32'(occupancy), 32'd1);
        unlook();

        // Fill 0x200..0x23C then 0x300: evicts 0x100 and 0x200
        for (int i = 0; i < 16; i++) begin
            wr(c_PC, 32'h200 + 32'(4 * i));
            wr(c_CFG, 32'(i));
        end
        wr(c_PC, 32'h300);
        wr(c_CFG, 32'h0000_0445);
        chk("full_occ", 32'(occupancy), 32'd16);
        look(32'h200);
        chk("evict_200", 32'(valid), 32'd0);
        look(32'h100);
        chk("evict_100", 32'(valid), 32'd0);
        look(32'h23C);
        chk("keep_23c", 32'(valid), 32'd1);
        chk("keep_23c_rs1", 32'(sasa_rs1), 32'd15);
        look(32'h300);
        chk("new_300", 32'(valid), 32'd1);
        chk("new_300_rs1", 32'(sasa_rs1), 32'd5);
        chk("new_300_rs2", 32'(sasa_rs2), 32'd2);

        // Hit counting over 5 edges
        repeat (5) tick();
        unlook();
        chk("hits5", hit_count, 32'd5);

        // Flush keeps the counter
        wr(c_CTRL, 32'h1);
        look(32'h300);
        chk("flush_valid", 32'(valid), 32'd0);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_hits", hit_count, 32'd5);
        unlook();

        // Enable gating holds the counter
        wr(c_PC, 32'h400);
        wr(c_CFG, 32'h0000_0021);
        look(32'h400);
        repeat (2) tick();
        unlook();
        chk("dis_valid", 32'(valid), 32'd0);
        chk("dis_ppc", preceding_pc, 32'd0);
        repeat (3) tick();
        chk("dis_hits", hit_count, 32'd7);

        // Counter clear leaves entries intact
        wr(c_CTRL, 32'h2);
        chk("clr_hits", hit_count, 32'd0);
        look(32'h400);
        chk("clr_keep", 32'(valid), 32'd1);
        chk("clr_rs2", 32'(sasa_rs2), 32'd1);
        tick();
        unlook();
        chk("hits1", hit_count, 32'd1);

        // Both control bits
        wr(c_CTRL, 32'h3);
        chk("both_hits", hit_count, 32'd0);
        chk("both_occ", 32'(occupancy), 32'd0);

        // Second word 0 overwrites the pending PC
        wr(c_PC, 32'h700);
        wr(c_PC, 32'h704);
        wr(c_CFG, 32'h0000_0022);
        look(32'h704);
        chk("rew0_hit", 32'(valid), 32'd1);
        chk("rew0_rs2", 32'(sasa_rs2), 32'd1);
        look(32'h700);
        chk("rew0_miss", 32'(valid), 32'd0);
        unlook();

        // Reset in PC_HELD discards the pending PC
        wr(c_PC, 32'h600);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        wr(c_CFG, 32'h0000_0021);
        chk("rstheld_occ", 32'(occupancy), 32'd0);
        look(32'h600);
        chk("rstheld_valid", 32'(valid), 32'd0);
        look(32'h0);
        chk("rstheld_pc0", 32'(valid), 32'd0);
        unlook();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
